// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   8N1 UART transmitter (1 start, 8 data LSB-first, 1 stop) fed by a byte FIFO.
//   Host logic pushes bytes with a valid/ready handshake. Queued bytes are
//   serialised back-to-back on o_Tx_Serial with no idle gap between frames.
//   Bit timing runs directly on osc_clk (CLKS_PER_BIT cycles per bit).
//
//   Handshake: a byte is taken on any rising edge of osc_clk where
//   i_Tx_DV=1 and o_Tx_Ready=1. o_Tx_Ready depends only on the registered
//   FIFO count, never on i_Tx_DV. A push while not ready is dropped and
//   flagged by a one-cycle o_Tx_Overflow pulse on the following cycle.
//
// Ports
//   osc_clk        system clock, all logic on the rising edge
//   i_Rst          asynchronous, active-high reset
//   i_Tx_DV        push request
//   i_Tx_Byte      byte to push
//   o_Tx_Ready     FIFO not full
//   o_Fifo_Count   bytes waiting (excludes the byte being shifted)
//   o_Tx_Overflow  one-cycle pulse: push attempted while full
//   o_Tx_Serial    UART line, idle high, registered
//   o_Tx_Active    high for every cycle of every frame on the line
//   o_Tx_Done      one-cycle pulse on the last stop-bit cycle of a frame
//   dbg_state      current transmitter FSM state (debug visibility)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 1181,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic              osc_clk,
    input  logic              i_Rst,
    input  logic              i_Tx_DV,
    input  logic [7:0]        i_Tx_Byte,
    output logic              o_Tx_Ready,
    output logic [ADDR_W:0]   o_Fifo_Count,
    output logic              o_Tx_Overflow,
    output logic              o_Tx_Serial,
    output logic              o_Tx_Active,
    output logic              o_Tx_Done,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    // Three-bit encoding leaves spare codes; any of them falls back to IDLE.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3
    } tx_state_t;

    tx_state_t          state, state_nxt;
    logic [CNT_W-1:0]   clk_cnt, clk_cnt_nxt;
    logic [2:0]         bit_idx, bit_idx_nxt;
    logic [7:0]         shift, shift_nxt;
    logic               line_nxt, active_nxt, done_nxt;
    logic               bit_end;

    logic [7:0]         mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
    logic [ADDR_W:0]    count;
    logic               push, pop;

    // ---------------------------------------------------------------- FIFO
    assign o_Tx_Ready   = (count < DEPTH_CNT);
    assign o_Fifo_Count = count;
    // Ready comes from the pre-edge count, so a push into a full FIFO is
    // rejected even when a pop frees a slot on the same edge.
    assign push         = i_Tx_DV && o_Tx_Ready;

    always_ff @(posedge osc_clk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage needs no reset: the count/pointers define which entries are valid.
    always_ff @(posedge osc_clk) begin
        if (push) mem[wr_ptr] <= i_Tx_Byte;
    end

    // ------------------------------------------------------------ FSM
    assign bit_end   = (clk_cnt == LAST_CNT);
    assign dbg_state = state;

    always_ff @(posedge osc_clk or posedge i_Rst) begin
        if (i_Rst) begin
            state         <= S_IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            shift         <= '0;
            o_Tx_Serial   <= 1'b1;
            o_Tx_Active   <= 1'b0;
            o_Tx_Done     <= 1'b0;
            o_Tx_Overflow <= 1'b0;
        end else begin
            state         <= state_nxt;
            clk_cnt       <= clk_cnt_nxt;
            bit_idx       <= bit_idx_nxt;
            shift         <= shift_nxt;
            o_Tx_Serial   <= line_nxt;
            o_Tx_Active   <= active_nxt;
            o_Tx_Done     <= done_nxt;
            o_Tx_Overflow <= i_Tx_DV && !o_Tx_Ready;
        end
    end

    // Line outputs are registered from the current state, so the line, Active
    // and Done all trail the state register by exactly one cycle and stay
    // mutually aligned.
    always_comb begin
        state_nxt   = state;
        clk_cnt_nxt = clk_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        pop         = 1'b0;
        line_nxt    = 1'b1;
        active_nxt  = 1'b0;
        done_nxt    = 1'b0;

        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop         = 1'b1;
                    shift_nxt   = mem[rd_ptr];
                    clk_cnt_nxt = '0;
                    state_nxt   = S_START;
                end
            end
            S_START: begin
                line_nxt   = 1'b0;
                active_nxt = 1'b1;
                if (bit_end) begin
                    clk_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = S_DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            S_DATA: begin
                line_nxt   = shift[bit_idx];
                active_nxt = 1'b1;
                if (bit_end) begin
                    clk_cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            S_STOP: begin
                active_nxt = 1'b1;
                if (bit_end) begin
                    done_nxt    = 1'b1;
                    clk_cnt_nxt = '0;
                    // Chaining straight into START keeps the frame period at
                    // exactly 10 bit times when more bytes are queued.
                    if (count != '0) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        state_nxt = S_START;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt   = S_IDLE;
                clk_cnt_nxt = '0;
                bit_idx_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Bench for uart_tx_fifo with CLKS_PER_BIT=8, FIFO_DEPTH=16.
//   A frame-level reference model (byte queue + frame timer + line timeline)
//   predicts every output each cycle; a mid-bit UART decoder recovers bytes
//   from the line and matches them against the queue of accepted bytes.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CPB   = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int FRAME = 10 * CPB;

    // ------------------------------------------------ clock / reset / DUT
    logic          osc_clk   = 1'b0;
    logic          i_Rst     = 1'b0;
    logic          i_Tx_DV   = 1'b0;
    logic [7:0]    i_Tx_Byte = 8'h00;
    logic          o_Tx_Ready;
    logic [AW:0]   o_Fifo_Count;
    logic          o_Tx_Overflow;
    logic          o_Tx_Serial;
    logic          o_Tx_Active;
    logic          o_Tx_Done;
    logic [2:0]    dbg_state;

    always #5 osc_clk = ~osc_clk;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .ADDR_W       (AW)
    ) dut (
        .osc_clk       (osc_clk),
        .i_Rst         (i_Rst),
        .i_Tx_DV       (i_Tx_DV),
        .i_Tx_Byte     (i_Tx_Byte),
        .o_Tx_Ready    (o_Tx_Ready),
        .o_Fifo_Count  (o_Fifo_Count),
        .o_Tx_Overflow (o_Tx_Overflow),
        .o_Tx_Serial   (o_Tx_Serial),
        .o_Tx_Active   (o_Tx_Active),
        .o_Tx_Done     (o_Tx_Done),
        .dbg_state     (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // ------------------------------------------------ reference model
    logic [7:0] m_q[$];          // bytes waiting in the FIFO
    logic [7:0] exp_q[$];        // accepted bytes not yet seen on the line
    logic [7:0] rx_log[$];       // bytes recovered by the decoder
    int         m_timer;         // edges until the current frame slot ends
    logic       m_pend;          // byte popped, line starts next edge
    logic [7:0] m_pend_byte;
    int         m_line_k;        // cycle index within the frame on the line, -1 idle
    logic [7:0] m_line_byte;
    logic       m_ovf;
    logic       m_acc;
    int         rx_k;
    logic [7:0] rx_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        exp_q.delete();
        m_timer  = 0;
        m_pend   = 1'b0;
        m_line_k = -1;
        m_ovf    = 1'b0;
        m_acc    = 1'b0;
        rx_k     = -1;
    endtask

    function automatic logic exp_serial();
        int b;
        if (m_line_k < 0) return 1'b1;
        b = m_line_k / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return m_line_byte[b-1];
    endfunction

    // One rising edge of the block, described in frame terms.
    task automatic model_edge(input logic dv, input logic [7:0] data);
        logic full;
        full  = (m_q.size() >= DEPTH);
        m_ovf = dv && full;
        if (m_line_k >= 0) begin
            m_line_k++;
            if (m_line_k == FRAME) m_line_k = -1;
        end
        if (m_pend) begin
            m_line_byte = m_pend_byte;
            m_line_k    = 0;
            m_pend      = 1'b0;
        end
        if (m_timer > 0) m_timer--;
        if (m_timer == 0 && m_q.size() > 0) begin
            m_pend_byte = m_q.pop_front();
            m_pend      = 1'b1;
            m_timer     = FRAME;
        end
        m_acc = dv && !full;
        if (m_acc) begin
            m_q.push_back(data);
            exp_q.push_back(data);
        end
    endtask

    // Mid-bit sampling receiver, fed once per cycle.
    task automatic rx_sample(input logic ser);
        int b;
        if (rx_k < 0) begin
            if (ser == 1'b0) rx_k = 0;
        end else begin
            rx_k++;
        end
        if (rx_k >= 0 && (rx_k % CPB) == CPB / 2) begin
            b = rx_k / CPB;
            if (b == 0) begin
                check("rx_start_bit", ser, 1'b0);
            end else if (b <= 8) begin
                rx_b[b-1] = ser;
            end else begin
                check("rx_stop_bit", ser, 1'b1);
                rx_log.push_back(rx_b);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_b);
                end else begin
                    check("rx_byte", rx_b, exp_q.pop_front());
                end
                rx_k = -1;
            end
        end
    endtask

    // ------------------------------------------------ driver
    task automatic step(input logic dv, input logic [7:0] data);
        i_Tx_DV   = dv;
        i_Tx_Byte = data;
        @(posedge osc_clk);
        model_edge(dv, data);
        @(negedge osc_clk);
        check("count",    o_Fifo_Count,  m_q.size());
        check("ready",    o_Tx_Ready,    m_q.size() < DEPTH);
        check("overflow", o_Tx_Overflow, m_ovf);
        check("serial",   o_Tx_Serial,   exp_serial());
        check("active",   o_Tx_Active,   m_line_k >= 0);
        check("done",     o_Tx_Done,     m_line_k == FRAME - 1);
        rx_sample(o_Tx_Serial);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while (!(m_q.size() == 0 && !m_pend && m_line_k < 0) && n < max_cycles) begin
            step(1'b0, 8'h00);
            n++;
        end
        check("drain_timeout", n < max_cycles, 1'b1);
        repeat (2) step(1'b0, 8'h00);
        check("all_bytes_sent", exp_q.size(), 0);
    endtask

    // Reset asserted between clock edges; outputs must clear without a clock.
    task automatic async_reset();
        #2 i_Rst = 1'b1;
        i_Tx_DV = 1'b0;
        #1;
        check("rst_serial",   o_Tx_Serial,   1'b1);
        check("rst_active",   o_Tx_Active,   1'b0);
        check("rst_done",     o_Tx_Done,     1'b0);
        check("rst_overflow", o_Tx_Overflow, 1'b0);
        check("rst_count",    o_Fifo_Count,  0);
        check("rst_ready",    o_Tx_Ready,    1'b1);
        check("rst_state",    dbg_state,     3'd0);
        model_clear();
        repeat (3) @(negedge osc_clk);
        i_Rst = 1'b0;
    endtask

    // ------------------------------------------------ table for one frame
    typedef struct {
        int         cycles;
        logic       dv;
        logic [7:0] data;
        logic       ser;
        logic       act;
        logic [4:0] cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int act_cnt, done_cnt, done_at, run, n, sent;
        logic seen;
        logic [7:0] t2_bytes[3];
        logic [4:0] t2_cnt[3];

        // 0x55 frame: push, pop, start, bits 1,0,1,0,1,0,1,0, stop, idle.
        tbl[0]  = '{1, 1'b1, 8'h55, 1'b1, 1'b0, 5'd1};
        tbl[1]  = '{1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0};
        tbl[2]  = '{CPB, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0};
        tbl[3]  = '{CPB, 1'b0, 8'h00, 1'b1, 1'b1, 5'd0};
        tbl[4]  = '{CPB, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0};
        tbl[5]  = '{CPB, 1'b0, 8'h00, 1'b1, 1'b1, 5'd0};
        tbl[6]  = '{CPB, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0};
        tbl[7]  = '{CPB, 1'b0, 8'h00, 1'b1, 1'b1, 5'd0};
        tbl[8]  = '{CPB, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0};
        tbl[9]  = '{CPB, 1'b0, 8'h00, 1'b1, 1'b1, 5'd0};
        tbl[10] = '{CPB, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0};
        tbl[11] = '{CPB, 1'b0, 8'h00, 1'b1, 1'b1, 5'd0};
        tbl[12] = '{4,   1'b0, 8'h00, 1'b1, 1'b0, 5'd0};

        // ---- power-on reset
        model_clear();
        #1 i_Rst = 1'b1;
        #1;
        check("por_serial",   o_Tx_Serial,   1'b1);
        check("por_active",   o_Tx_Active,   1'b0);
        check("por_done",     o_Tx_Done,     1'b0);
        check("por_overflow", o_Tx_Overflow, 1'b0);
        check("por_count",    o_Fifo_Count,  0);
        check("por_ready",    o_Tx_Ready,    1'b1);
        repeat (2) @(negedge osc_clk);
        i_Rst = 1'b0;

        // ---- single 0x55 frame from the table
        act_cnt = 0; done_cnt = 0; done_at = -1;
        rx_log.delete();
        for (int r = 0; r < 13; r++) begin
            for (int c = 0; c < tbl[r].cycles; c++) begin
                step(tbl[r].dv, tbl[r].data);
                check("t1_serial", o_Tx_Serial,  tbl[r].ser);
                check("t1_active", o_Tx_Active,  tbl[r].act);
                check("t1_count",  o_Fifo_Count, tbl[r].cnt);
                if (o_Tx_Active) act_cnt++;
                if (o_Tx_Done) begin
                    done_cnt++;
                    done_at = act_cnt;
                end
            end
        end
        check("t1_active_len", act_cnt, FRAME);
        check("t1_done_count", done_cnt, 1);
        check("t1_done_cycle", done_at, FRAME);
        check("t1_rx_len", rx_log.size(), 1);
        if (rx_log.size() == 1) check("t1_rx_byte", rx_log[0], 8'h55);

        // ---- three bytes back-to-back. The first byte is popped on the edge
        // after its push, so the second push coincides with that pop.
        t2_bytes[0] = 8'hA5; t2_bytes[1] = 8'h3C; t2_bytes[2] = 8'hFF;
        t2_cnt[0] = 5'd1; t2_cnt[1] = 5'd1; t2_cnt[2] = 5'd2;
        rx_log.delete();
        run = 0; seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step(i < 3, (i < 3) ? t2_bytes[i] : 8'h00);
            if (i < 3) check("t2_count", o_Fifo_Count, t2_cnt[i]);
            if (o_Tx_Active) begin
                run++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
        end
        check("t2_active_run", run, 3 * FRAME);
        check("t2_rx_len", rx_log.size(), 3);
        for (int i = 0; i < 3 && i < rx_log.size(); i++) check("t2_rx_byte", rx_log[i], t2_bytes[i]);
        drain(500);

        // ---- fill to full while the first frame is on the line
        for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h10 + i));
        check("t3_count_full", o_Fifo_Count, 16);
        check("t3_ready_low",  o_Tx_Ready,   1'b0);
        step(1'b1, 8'hEE);
        check("t3_overflow",   o_Tx_Overflow, 1'b1);
        check("t3_count_hold", o_Fifo_Count,  16);
        step(1'b0, 8'h00);
        check("t3_overflow_pulse", o_Tx_Overflow, 1'b0);

        // ---- push coincident with the pop at the end of a frame
        n = 0;
        while (m_timer != 1 && n < 2 * FRAME) begin
            step(1'b0, 8'h00);
            n++;
        end
        check("t4_wait_timeout", n < 2 * FRAME, 1'b1);
        check("t4_count_before", o_Fifo_Count, 16);
        step(1'b1, 8'hEE);
        check("t4_overflow", o_Tx_Overflow, 1'b1);
        check("t4_count",    o_Fifo_Count,  15);
        step(1'b1, 8'h77);
        check("t4_count_refill", o_Fifo_Count, 16);
        check("t4_no_overflow",  o_Tx_Overflow, 1'b0);
        drain(3000);

        // ---- reset mid-DATA with four bytes queued
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i));
        check("t5_queued", o_Fifo_Count, 4);
        repeat (30) step(1'b0, 8'h00);
        check("t5_in_data", dbg_state, 3'd2);
        async_reset();
        rx_log.delete();
        repeat (200) step(1'b0, 8'h00);
        check("t5_quiet_rx", rx_log.size(), 0);
        step(1'b1, 8'h01);
        drain(500);
        check("t5_rx_len", rx_log.size(), 1);
        if (rx_log.size() == 1) check("t5_rx_byte", rx_log[0], 8'h01);

        // ---- 40 random bytes, random push rate, through the pointer wrap
        sent = 0; n = 0;
        while (sent < 40 && n < 20000) begin
            if ($urandom_range(0, 3) != 0) step(1'b1, 8'($urandom_range(0, 255)));
            else                           step(1'b0, 8'h00);
            if (m_acc) sent++;
            n++;
        end
        check("t6_sent_timeout", sent, 40);
        drain(4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
